// File: rtl/aes_sbox_unit.sv
// aes_sbox_unit: multi-beat AES S-box substitution engine, LANES bytes/beat.
// Define AES_SBOX_FWD_EN to add the forward table; otherwise inverse-only.
module aes_sbox_unit #(
   parameter int WORD_BYTES = 16,
   parameter int LANES      = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_inv,
   input  logic [8*WORD_BYTES-1:0]   in_word,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [8*WORD_BYTES-1:0]   out_word,
   output logic                      busy
);

   localparam int BEATS = WORD_BYTES / LANES;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LW    = 8 * LANES;
   localparam int TOP   = 8 * WORD_BYTES - 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   // GF(2^8) helpers used only to build the lookup tables at elaboration
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                         input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse, and maps 0 to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] y;
      logic [7:0] e;
      r = 8'h01;
      y = a;
      e = 8'd254;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = gf_mul(r, y);
         y = gf_mul(y, y);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

   // inverse table is built by scattering the forward images
   function automatic logic [2047:0] gen_inv();
      logic [2047:0] t;
      t = '0;
      for (int i = 0; i < 256; i++)
         t[8*int'(sbox_fwd(8'(i))) +: 8] = 8'(i);
      return t;
   endfunction

   localparam logic [2047:0] INV_TBL = gen_inv();

`ifdef AES_SBOX_FWD_EN
   function automatic logic [2047:0] gen_fwd();
      logic [2047:0] t;
      t = '0;
      for (int i = 0; i < 256; i++)
         t[8*i +: 8] = sbox_fwd(8'(i));
      return t;
   endfunction

   localparam logic [2047:0] FWD_TBL = gen_fwd();
`endif

   typedef enum logic [1:0] {
      IDLE,
      SUB,
      DONE
   } state_t;

   state_t              state;
   logic [TOP:0]        work;
   logic [CW-1:0]       cnt;
   logic [LW-1:0]       lane_in;
   logic [LW-1:0]       lane_out;
   logic                accept;

`ifdef AES_SBOX_FWD_EN
   logic                mode;
`else
   logic                unused_inv;
   assign unused_inv = in_inv;
`endif

   assign in_ready = !reset &&
                     ((state == IDLE) || ((state == DONE) && out_ready));
   assign accept   = in_valid && in_ready;
   assign out_word = work;
   assign busy     = (state != IDLE);

   // pick the slice of the working word addressed by the beat counter
   always_comb begin
      lane_in = '0;
      for (int b = 0; b < BEATS; b++)
         if (cnt == CW'(b)) lane_in = work[TOP-LW*b -: LW];
   end

   // per-lane table lookup
   always_comb begin
      lane_out = '0;
      for (int l = 0; l < LANES; l++) begin
`ifdef AES_SBOX_FWD_EN
         if (mode)
            lane_out[8*l +: 8] = INV_TBL[8*int'(lane_in[8*l +: 8]) +: 8];
         else
            lane_out[8*l +: 8] = FWD_TBL[8*int'(lane_in[8*l +: 8]) +: 8];
`else
         lane_out[8*l +: 8] = INV_TBL[8*int'(lane_in[8*l +: 8]) +: 8];
`endif
      end
   end

   // control FSM, working register and registered out_valid
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         work      <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
`ifdef AES_SBOX_FWD_EN
         mode      <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  work  <= in_word;
                  cnt   <= '0;
                  state <= SUB;
`ifdef AES_SBOX_FWD_EN
                  mode  <= in_inv;
`endif
               end
            end
            SUB: begin
               for (int b = 0; b < BEATS; b++)
                  if (cnt == CW'(b)) work[TOP-LW*b -: LW] <= lane_out;
               if (cnt == LAST) begin
                  cnt       <= '0;
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (accept) begin
                     work  <= in_word;
                     cnt   <= '0;
                     state <= SUB;
`ifdef AES_SBOX_FWD_EN
                     mode  <= in_inv;
`endif
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_sbox_unit.sv
// tb_aes_sbox_unit: directed scoreboard bench for aes_sbox_unit.
// Expected words come from a log/antilog GF(2^8) model built at time 0.
module tb_aes_sbox_unit;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid, in_ready, in_inv;
   logic          out_valid, out_ready, busy;
   logic [127:0]  in_word, out_word;

   logic          v1, r1, inv1, ov1, ordy1, busy1;
   logic [127:0]  w1, ow1;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [127:0]  sb[$];

   logic [7:0]    exp_t[256];
   logic [7:0]    log_t[256];
   logic [7:0]    fwd_t[256];
   logic [7:0]    inv_t[256];

   always #5 clk = ~clk;

   aes_sbox_unit #(.WORD_BYTES(16), .LANES(4)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_inv    (in_inv),
      .in_word   (in_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .busy      (busy)
   );

   aes_sbox_unit #(.WORD_BYTES(16), .LANES(16)) u_dut1 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (v1),
      .in_ready  (r1),
      .in_inv    (inv1),
      .in_word   (w1),
      .out_valid (ov1),
      .out_ready (ordy1),
      .out_word  (ow1),
      .busy      (busy1)
   );

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic build_model();
      logic [7:0] x, b, s, c;
      c = 8'h63;
      exp_t[0] = 8'h01;
      for (int i = 1; i < 256; i++) begin
         x = exp_t[i-1];
         exp_t[i] = x ^ {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      log_t[0] = 8'h00;
      for (int i = 0; i < 255; i++) log_t[exp_t[i]] = 8'(i);
      for (int i = 0; i < 256; i++) begin
         x = 8'(i);
         b = (i == 0) ? 8'h00 : exp_t[(255 - int'(log_t[x])) % 255];
         for (int k = 0; k < 8; k++)
            s[k] = b[k] ^ b[(k+4)%8] ^ b[(k+5)%8] ^ b[(k+6)%8]
                   ^ b[(k+7)%8] ^ c[k];
         fwd_t[i] = s;
         inv_t[s] = x;
      end
   endtask

   function automatic logic [127:0] model(input logic [127:0] w,
                                          input logic inv);
      logic [127:0] r;
      logic         e;
`ifdef AES_SBOX_FWD_EN
      e = inv;
`else
      e = inv | 1'b1;
`endif
      for (int k = 0; k < 16; k++)
         r[8*k +: 8] = e ? inv_t[w[8*k +: 8]] : fwd_t[w[8*k +: 8]];
      return r;
   endfunction

   // called at a negedge; returns at the negedge after the acceptance edge
   task automatic send(input logic [127:0] w, input logic inv,
                       input string tag);
      in_word  = w;
      in_inv   = inv;
      in_valid = 1'b1;
      #1;
      chk({tag, "_rdy"}, 128'(in_ready), 128'(1'b1));
      sb.push_back(model(w, inv));
      @(negedge clk);
      in_valid = 1'b0;
      in_word  = {$urandom, $urandom, $urandom, $urandom};
      in_inv   = 1'($urandom_range(0, 1));
   endtask

   task automatic expect_result(input int lat_exp, input string tag,
                                output logic [127:0] got);
      int lat;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, 128'(lat), 128'(lat_exp));
      chk({tag, "_ov"}, 128'(out_valid), 128'(1'b1));
      got = '0;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_sb observed=empty expected=entry", tag);
      end else begin
         got = sb.pop_front();
         chk({tag, "_word"}, out_word, got);
      end
   endtask

   initial begin
      logic [127:0] e, e2, w0, wa, wb;
      int           lat, cnt;

      build_model();
      reset    = 1'b1;
      in_valid = 1'b0;
      in_inv   = 1'b0;
      in_word  = '0;
      out_ready = 1'b1;
      v1 = 1'b0; inv1 = 1'b0; w1 = '0; ordy1 = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_ready", 128'(in_ready), 128'(1'b0));
      chk("rst_ovalid", 128'(out_valid), 128'(1'b0));
      chk("rst_oword", out_word, 128'(0));
      chk("rst_busy", 128'(busy), 128'(1'b0));
      reset = 1'b0;
      @(negedge clk);
      chk("rel_ready", 128'(in_ready), 128'(1'b1));

      // all 0x63 inverse-substitutes to zero; single-cycle out_valid
      send({16{8'h63}}, 1'b1, "t1");
      expect_result(5, "t1", e);
      chk("t1_zero", out_word, 128'(0));
      @(negedge clk);
      chk("t1_pulse", 128'(out_valid), 128'(1'b0));
      chk("t1_idle", 128'(busy), 128'(1'b0));

      // round trip, second word accepted back-to-back in DONE
      w0 = 128'h00112233445566778899aabbccddeeff;
      send(w0, 1'b0, "t2f");
      expect_result(5, "t2f", e);
`ifdef AES_SBOX_FWD_EN
      chk("t2_prefix", 128'(out_word[127:96]), 128'(32'h638293c3));
`endif
      send(e, 1'b1, "t2i");
      chk("t2_b2b_ov", 128'(out_valid), 128'(1'b0));
      expect_result(5, "t2i", e2);
`ifdef AES_SBOX_FWD_EN
      chk("t2_orig", out_word, w0);
`endif
      @(negedge clk);

      // backpressure hold with a pending (ignored) request
      out_ready = 1'b0;
      wa = {$urandom, $urandom, $urandom, $urandom};
      wb = {$urandom, $urandom, $urandom, $urandom};
      send(wa, 1'b0, "t3a");
      expect_result(5, "t3a", e);
      in_valid = 1'b1;
      in_word  = ~wb;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t3_hold_ov", 128'(out_valid), 128'(1'b1));
         chk("t3_hold_w", out_word, e);
         chk("t3_hold_rdy", 128'(in_ready), 128'(1'b0));
      end
      out_ready = 1'b1;
      send(wb, 1'b1, "t3b");
      chk("t3_drop", 128'(out_valid), 128'(1'b0));
      expect_result(5, "t3b", e);
      @(negedge clk);

      // reset during SUB beat 2 drops the word
      send({$urandom, $urandom, $urandom, $urandom}, 1'b1, "t4");
      @(negedge clk);
      @(negedge clk);
      chk("t4_busy", 128'(busy), 128'(1'b1));
      reset = 1'b1;
      #1;
      chk("t4_rst_rdy", 128'(in_ready), 128'(1'b0));
      @(negedge clk);
      reset = 1'b0;
      chk("t4_busy0", 128'(busy), 128'(1'b0));
      chk("t4_ov0", 128'(out_valid), 128'(1'b0));
      chk("t4_ow0", out_word, 128'(0));
      #1;
      chk("t4_rdy", 128'(in_ready), 128'(1'b1));
      sb.delete();
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("t4_noresult", 128'(cnt), 128'(0));

      // back-to-back random words, random mode
      for (int i = 0; i < 4; i++) begin
         send({$urandom, $urandom, $urandom, $urandom},
              1'($urandom_range(0, 1)), "rnd");
         expect_result(5, "rnd", e);
      end
      @(negedge clk);
      chk("rnd_end_ov", 128'(out_valid), 128'(1'b0));

      // in_inv=0 on all 0xed
      send({16{8'hed}}, 1'b0, "t6");
      expect_result(5, "t6", e);
`ifndef AES_SBOX_FWD_EN
      chk("t6_inv53", out_word, {16{8'h53}});
`endif
      @(negedge clk);

      // single-beat instance
      w1   = {{15{8'h7c}}, 8'hff};
      inv1 = 1'b1;
      v1   = 1'b1;
      #1;
      chk("t5_rdy", 128'(r1), 128'(1'b1));
      @(negedge clk);
      v1  = 1'b0;
      lat = 1;
      while (!ov1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk("t5_lat", 128'(lat), 128'(2));
      chk("t5_word", ow1, {{15{8'h01}}, 8'h7d});
      @(negedge clk);
      chk("t5_pulse", 128'(ov1), 128'(1'b0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/aes_sbox_unit.md
# aes_sbox_unit

- Parametrised, handshaked byte-substitution engine for the AES datapath.
- Substitutes a WORD_BYTES-wide word through the forward or inverse AES S-box, processing LANES bytes per cycle and iterating over WORD_BYTES/LANES beats under a small FSM.
- Sits between the round-key/state registers and the round logic of the cipher cores; one instance serves both the encrypt and decrypt paths.

## Interface
Parameters:
- WORD_BYTES, 16, bytes per word; must be an integer multiple of LANES.
- LANES, 4, S-box lookups per cycle; BEATS = WORD_BYTES/LANES.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  reset, synchronous, active-high.
- in_valid  input  1  input word valid.
- in_ready  output  1  unit can accept a word.
- in_inv  input  1  1 = inverse S-box, 0 = forward S-box; sampled at acceptance.
- in_word  input  8*WORD_BYTES  word to substitute.
- out_valid  output  1  out_word holds a completed result.
- out_ready  input  1  consumer takes result.
- out_word  output  8*WORD_BYTES  substituted word.
- busy  output  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, SUB, DONE.
- Acceptance occurs when in_valid && in_ready is sampled at a clock edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready); it is forced to 0 while reset is high.
- IDLE:
  - On acceptance, latch in_word into the working register and latch in_inv into the mode flag.
  - Clear the beat counter and go to SUB.
- SUB:
  - Each cycle, replace LANES bytes of the working register with their S-box images (table selected by the mode flag) and increment the beat counter.
  - Beat k covers bytes [8*WORD_BYTES-1-8*LANES*k -: 8*LANES], so beat 0 covers the most significant bytes.
  - After the beat with counter == BEATS-1, the counter clears and the FSM goes to DONE.
- DONE:
  - out_valid=1 and out_word = working register.
  - On out_ready=1 without acceptance, go to IDLE.
  - On out_ready=1 with simultaneous acceptance, load the new word and mode, clear the counter and go directly to SUB.
- Changes to in_inv or in_word outside the acceptance cycle are ignored.
- Counter width is clog2(BEATS), minimum 1 bit. With BEATS=1 the counter stays 0 and SUB lasts exactly one cycle.
- Each lane is the standard FIPS-197 table; the inverse table is bijective with the forward one, e.g. inv(0x63)=0x00, inv(0xed)=0x53.

## Timing
- Reset values: state IDLE, working register 0, mode 0, counter 0, out_valid 0, out_word 0, busy 0, in_ready 0 during reset and 1 in the first cycle after reset release.
- Latency, for acceptance in cycle t:
  - Cycles t+1..t+BEATS are SUB.
  - out_valid rises in cycle t+BEATS+1, so latency is BEATS+1 cycles.
  - Default parameters give 5 cycles; BEATS=1 gives 2.
- Throughput:
  - One word per BEATS+1 cycles with out_ready held high and back-to-back acceptance in DONE.
  - One word per BEATS+2 cycles if each word is presented in IDLE.
- Backpressure: while out_valid=1 and out_ready=0, out_word and out_valid hold stable and in_ready=0.
- Reset mid-operation (SUB or DONE): the word is dropped, out_valid is 0 in the next cycle, and no partial result is ever presented.
- out_word is driven from the register; there is no combinational path from in_word to out_word.

## Configuration
- AES_SBOX_FWD_EN defined: both the forward and inverse tables are compiled in, and the latched in_inv selects between them per word.
- AES_SBOX_FWD_EN undefined: only the inverse table is compiled in, in_inv is ignored, and every word is inverse-substituted. Used for decrypt-only builds to save area.

## Test plan
1. Defaults, macro defined, in_inv=1, in_word=16×0x63, out_ready=1 → out_word=0 in cycle t+5, out_valid high for exactly 1 cycle.
2. Round trip: forward on 0x00112233445566778899aabbccddeeff → out_word begins 0x638293c3; feeding that result back with in_inv=1 → original word.
3. Backpressure: hold out_ready=0 for 10 cycles in DONE → out_word stable and in_ready=0. Then out_ready=1 with in_valid=1 in the same cycle → second word accepted that cycle, out_valid=0 in the next cycle, second result out 5 cycles after acceptance.
4. Assert reset for 1 cycle during SUB beat 2 → busy=0 and out_valid=0 next cycle, in_ready=1 after release, no result emitted.
5. LANES=16 (BEATS=1), in_inv=1, all bytes 0x7c except the low byte 0xff → out_word all 0x01 except the low byte 0x7d, latency 2 cycles.
6. Macro undefined, in_inv=0, all bytes 0xed → all bytes 0x53 (inverse applied despite in_inv=0).
